// File: rtl/fft_pkg.sv
// Shared FFT constants, Q.8 twiddle tables for N=16 and the output saturator.
// The butterfly stage imports this package as well.
package fft_pkg;

    localparam int FFT_DATA_W    = 16;
    localparam int FFT_TW_W      = 16;
    localparam int FFT_FRAC_BITS = 8;
    localparam int FFT_N_POINT   = 16;
    localparam int FFT_K_W       = 3;

    // Width of a product sum: one guard bit above the full product width.
    localparam int FFT_SUM_W     = FFT_DATA_W + FFT_TW_W + 1;

    // W_N^k = cos - j*sin, stored as cos and msin = -sin, 1.0 = 256.
    localparam logic signed [FFT_TW_W-1:0] TW_COS [FFT_N_POINT/2] = '{
        16'sd256,  16'sd237,  16'sd181,  16'sd98,
        16'sd0,   -16'sd98,  -16'sd181, -16'sd237
    };
    localparam logic signed [FFT_TW_W-1:0] TW_MSIN [FFT_N_POINT/2] = '{
        16'sd0,   -16'sd98,  -16'sd181, -16'sd237,
        -16'sd256, -16'sd237, -16'sd181, -16'sd98
    };

    localparam logic signed [FFT_SUM_W-1:0] SAT_MAX =
        {{(FFT_SUM_W-FFT_DATA_W+1){1'b0}}, {(FFT_DATA_W-1){1'b1}}};
    localparam logic signed [FFT_SUM_W-1:0] SAT_MIN =
        {{(FFT_SUM_W-FFT_DATA_W+1){1'b1}}, {(FFT_DATA_W-1){1'b0}}};

    // Clamp a wide signed value into the DATA_WIDTH output range.
    function automatic logic signed [FFT_DATA_W-1:0] saturate(
        input logic signed [FFT_SUM_W-1:0] x
    );
        logic signed [FFT_SUM_W-1:0] c;
        if (x > SAT_MAX)
            c = SAT_MAX;
        else if (x < SAT_MIN)
            c = SAT_MIN;
        else
            c = x;
        return c[FFT_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup: index k -> {cos, -sin} in Q.8.
module fft_twiddle_rom
    import fft_pkg::*;
(
    input  logic        [FFT_K_W-1:0]  k,
    output logic signed [FFT_TW_W-1:0] cos_w,
    output logic signed [FFT_TW_W-1:0] msin_w
);

    assign cos_w  = TW_COS[k];
    assign msin_w = TW_MSIN[k];

endmodule

// File: rtl/fft_twiddle_mul.sv
// Three-stage pipelined complex multiply of a butterfly difference leg by W_N^k.
// A single global advance enable stalls every stage together, so a held output
// blocks the input side and nothing in flight is dropped or duplicated.
module fft_twiddle_mul
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_W,
    parameter int TW_WIDTH   = FFT_TW_W,
    parameter int FRAC_BITS  = FFT_FRAC_BITS,
    parameter int N_POINT    = FFT_N_POINT,
    parameter int K_WIDTH    = FFT_K_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_re,
    input  logic signed [DATA_WIDTH-1:0] in_im,
    input  logic        [K_WIDTH-1:0]    in_k,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_re,
    output logic signed [DATA_WIDTH-1:0] out_im
);

    localparam int PROD_W = DATA_WIDTH + TW_WIDTH;
    localparam int SUM_W  = PROD_W + 1;

    localparam logic signed [SUM_W-1:0] RND_HALF =
        {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

    // Add one half LSB then drop the fraction: round half toward +inf.
    function automatic logic signed [SUM_W-1:0] round_shift(
        input logic signed [SUM_W-1:0] x
    );
        return (x + RND_HALF) >>> FRAC_BITS;
    endfunction

    logic                         adv;
    logic signed [TW_WIDTH-1:0]   rom_cos, rom_msin;

    logic                         vld_p1, vld_p2, vld_p3;
    logic signed [DATA_WIDTH-1:0] re_p1, im_p1;
    logic signed [TW_WIDTH-1:0]   cos_p1, msin_p1;
    logic signed [PROD_W-1:0]     rr_p2, ii_p2, ri_p2, ir_p2;
    logic signed [DATA_WIDTH-1:0] re_p3, im_p3;

    logic signed [PROD_W-1:0]     re_x, im_x, cos_x, msin_x;
    logic signed [SUM_W-1:0]      sum_re, sum_im;

    assign adv      = !vld_p3 || out_ready;
    assign in_ready = adv;

    fft_twiddle_rom u_rom (
        .k      (in_k),
        .cos_w  (rom_cos),
        .msin_w (rom_msin)
    );

    // ---- stage 1: capture sample and its twiddle ----
    // Register the input leg and looked-up twiddle; bubbles ride along as vld_p1=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            re_p1   <= '0;
            im_p1   <= '0;
            cos_p1  <= '0;
            msin_p1 <= '0;
        end else if (adv) begin
            vld_p1  <= in_valid;
            re_p1   <= in_re;
            im_p1   <= in_im;
            cos_p1  <= rom_cos;
            msin_p1 <= rom_msin;
        end
    end

    assign re_x   = PROD_W'(re_p1);
    assign im_x   = PROD_W'(im_p1);
    assign cos_x  = PROD_W'(cos_p1);
    assign msin_x = PROD_W'(msin_p1);

    // ---- stage 2: four partial products ----
    // Full-width signed products; no precision is lost before the sums.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2 <= 1'b0;
            rr_p2  <= '0;
            ii_p2  <= '0;
            ri_p2  <= '0;
            ir_p2  <= '0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            rr_p2  <= re_x * cos_x;
            ii_p2  <= im_x * msin_x;
            ri_p2  <= re_x * msin_x;
            ir_p2  <= im_x * cos_x;
        end
    end

    assign sum_re = SUM_W'(rr_p2) - SUM_W'(ii_p2);
    assign sum_im = SUM_W'(ri_p2) + SUM_W'(ir_p2);

    // ---- stage 3: combine, round, saturate into the output register ----
    // Output register doubles as the hold buffer while downstream is not ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p3 <= 1'b0;
            re_p3  <= '0;
            im_p3  <= '0;
        end else if (adv) begin
            vld_p3 <= vld_p2;
            re_p3  <= saturate(round_shift(sum_re));
            im_p3  <= saturate(round_shift(sum_im));
        end
    end

    assign out_valid = vld_p3;
    assign out_re    = re_p3;
    assign out_im    = im_p3;

endmodule

// File: tb/tb_fft_twiddle_mul.sv
// Bench for fft_twiddle_mul: table-driven vectors plus directed latency,
// backpressure, asynchronous reset and random-stall sequences, all checked
// through an in-order scoreboard.
module tb_fft_twiddle_mul;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic        [2:0]  in_k = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int re;
        int im;
    } exp_t;

    typedef struct {
        int re;
        int im;
        int k;
        int exp_re;
        int exp_im;
    } vec_t;

    exp_t sb[$];

    localparam int COS_T  [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
    localparam int MSIN_T [8] = '{0, -98, -181, -237, -256, -237, -181, -98};

    fft_twiddle_mul dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im)
    );

    always #5 clk = ~clk;

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Reference: exact integer complex product, floor((x+128)/256), clamp.
    function automatic void model(input int re, input int im, input int k,
                                  output int ore, output int oim);
        longint sr, si;
        sr = longint'(re) * COS_T[k] - longint'(im) * MSIN_T[k];
        si = longint'(re) * MSIN_T[k] + longint'(im) * COS_T[k];
        ore = sat16((sr + 128) >>> 8);
        oim = sat16((si + 128) >>> 8);
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int re, input int im, input int k,
                        input int ere, input int eim);
        exp_t e;
        int   waited;
        in_re    = 16'(re);
        in_im    = 16'(im);
        in_k     = 3'(k);
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.re = ere;
                e.im = eim;
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            waited++;
            if (waited > 50) begin
                check("send_timeout", waited, 0);
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare every handshaked output with the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got (%0d,%0d), expected none",
                         out_re, out_im);
            end else begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                if (int'(out_re) != e.re || int'(out_im) != e.im) begin
                    miscompares++;
                    $display("FAIL out_data: got (%0d,%0d), expected (%0d,%0d)",
                             out_re, out_im, e.re, e.im);
                end
            end
        end
    end

    initial begin
        vec_t tbl[$];
        int   lat;
        int   held_re, held_im;
        int   ok;
        bit   done;

        tbl.push_back('{100,    -50,    0, 100,    -50});
        tbl.push_back('{100,    50,     4, 50,     -100});
        tbl.push_back('{256,    0,      2, 181,    -181});
        tbl.push_back('{32767,  32767,  2, 32767,  0});
        tbl.push_back('{-32768, -32768, 2, -32768, 0});
        tbl.push_back('{-1,     0,      2, -1,     1});
        tbl.push_back('{1,      0,      1, 1,      0});
        for (int k = 0; k < 8; k++)
            tbl.push_back('{256, 0, k, COS_T[k], MSIN_T[k]});

        // Reset state while rst is held low.
        #12;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_re", int'(out_re), 0);
        check("reset_out_im", int'(out_im), 0);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        check("ready_after_reset", int'(in_ready), 1);

        // Latency of a single unstalled sample, counting the accept edge.
        send(100, -50, 0, 100, -50);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 3);
        tick(3);

        // Table vectors, back to back.
        foreach (tbl[i])
            send(tbl[i].re, tbl[i].im, tbl[i].k, tbl[i].exp_re, tbl[i].exp_im);
        tick(6);

        // Backpressure: four samples with downstream stalled.
        out_ready = 1'b0;
        fork
            begin
                send(1000,  -2000, 1, 0, 0);
                sb[sb.size()-1] = '{0, 0};
            end
            begin
            end
        join
        // Fix up expectation for the sample just sent, then send the rest.
        begin
            int r, m;
            model(1000, -2000, 1, r, m);
            sb[sb.size()-1].re = r;
            sb[sb.size()-1].im = m;
        end
        fork
            begin
                int r, m;
                model(-3000, 700, 3, r, m);   send(-3000, 700, 3, r, m);
                model(12345, 321, 6, r, m);   send(12345, 321, 6, r, m);
                model(-5, -32768, 7, r, m);   send(-5, -32768, 7, r, m);
            end
            begin
                ok = 0;
                for (int c = 0; c < 20 && !ok; c++) begin
                    @(negedge clk);
                    if (out_valid) ok = 1;
                end
                check("stall_out_valid", ok, 1);
                held_re = int'(out_re);
                held_im = int'(out_im);
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("stall_in_ready", int'(in_ready), 0);
                    check("stall_hold_re", int'(out_re), held_re);
                    check("stall_hold_im", int'(out_im), held_im);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        tick(8);
        check("drain_after_stall", sb.size(), 0);

        // Asynchronous reset with two samples in flight.
        out_ready = 1'b0;
        send(300, -200, 1, 0, 0);
        send(-400, 123, 3, 0, 0);
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        check("inflight_valid", ok, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_re", int'(out_re), 0);
        check("async_rst_im", int'(out_im), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        tick(1);
        check("ready_after_rerelease", int'(in_ready), 1);
        tick(10);

        // Random data and k with random downstream stalls.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    int re, im, k, r, m;
                    re = int'($urandom_range(0, 65535)) - 32768;
                    im = int'($urandom_range(0, 65535)) - 32768;
                    k  = int'($urandom_range(0, 7));
                    model(re, im, k, r, m);
                    send(re, im, k, r, m);
                    if ($urandom_range(0, 3) == 0) tick(1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 60 && sb.size() != 0; c++) tick(1);
        check("final_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
